// File: rtl/cnt6_mod60.sv
`default_nettype none
// ============================================================================
// Module      : cnt6_mod60
// Description : Free-running modulo-(MAX_CNT+1) up-counter with async clear.
//               Source for the seconds/minutes digits of the clock datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt6_mod60 #(
  parameter int WIDTH   = 6,
  parameter int MAX_CNT = 59
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] out
);

  localparam logic [WIDTH-1:0] C_MAX_CNT = WIDTH'(MAX_CNT);
  localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;

  // ">=" rather than "==" so an upset into 60..63 falls back to 0 next edge.
  always_comb begin
    w_count_next = r_count + C_ONE;
    if (r_count >= C_MAX_CNT) begin
      w_count_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign out = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cnt6_mod60.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnt6_mod60
// Description : Scoreboard bench for cnt6_mod60 (default and 0..9 variants).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnt6_mod60;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rst_p_n;
  logic [5:0] out;
  logic [3:0] out_p;

  int checks = 0;
  int errors = 0;
  int edges;
  int sb[$];
  int sbp[$];

  cnt6_mod60 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .out   (out)
  );

  cnt6_mod60 #(.WIDTH(4), .MAX_CNT(9)) dut_p (
    .clk   (clk),
    .rst_n (rst_p_n),
    .out   (out_p)
  );

  always #10 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n   = 1'b0;
    rst_p_n = 1'b0;
    #1;
    checks++;
    if (out !== 6'd0) begin
      errors++;
      $display("FAIL reset_t0: out=%0d expected 0", out);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out !== 6'd0) begin
        errors++;
        $display("FAIL reset_hold: cycle %0d out=%0d expected 0", i, out);
      end
      checks++;
      if (out_p !== 4'd0) begin
        errors++;
        $display("FAIL reset_hold_p: cycle %0d out_p=%0d expected 0", i, out_p);
      end
    end
  endtask

  task automatic test_count();
    int exp;
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    for (int i = 0; i < 10; i++) begin
      edges++;
      sb.push_back(edges % 60);
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      if (out !== 6'(exp)) begin
        errors++;
        $display("FAIL count: edge %0d out=%0d expected %0d", edges, out, exp);
      end
    end
    checks++;
    if (out !== 6'd10) begin
      errors++;
      $display("FAIL count_10: out=%0d expected 10", out);
    end
  endtask

  task automatic test_wrap();
    int exp;
    int max_seen;
    max_seen = 0;
    while (edges < 100) begin
      edges++;
      sb.push_back(edges % 60);
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      if (out !== 6'(exp)) begin
        errors++;
        $display("FAIL wrap_seq: edge %0d out=%0d expected %0d", edges, out, exp);
      end
      if (int'(out) > max_seen) max_seen = int'(out);
      if (edges == 59) begin
        checks++;
        if (out !== 6'd59) begin
          errors++;
          $display("FAIL wrap_59: out=%0d expected 59", out);
        end
      end
      if (edges == 60) begin
        checks++;
        if (out !== 6'd0) begin
          errors++;
          $display("FAIL wrap_0: out=%0d expected 0", out);
        end
      end
    end
    checks++;
    if (max_seen > 59) begin
      errors++;
      $display("FAIL wrap_max: max out=%0d expected <= 59", max_seen);
    end
    checks++;
    if (out !== 6'd40) begin
      errors++;
      $display("FAIL wrap_100: out=%0d expected 40", out);
    end
  endtask

  task automatic test_async_reset();
    int exp;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    for (int i = 0; i < 37; i++) begin
      edges++;
      sb.push_back(edges % 60);
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      if (out !== 6'(exp)) begin
        errors++;
        $display("FAIL async_pre: edge %0d out=%0d expected %0d", edges, out, exp);
      end
    end
    #4;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 6'd0) begin
      errors++;
      $display("FAIL async_clear: out=%0d expected 0", out);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out !== 6'd0) begin
        errors++;
        $display("FAIL async_hold: edge %0d out=%0d expected 0", i, out);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    for (int i = 0; i < 3; i++) begin
      edges++;
      sb.push_back(edges % 60);
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      if (out !== 6'(exp)) begin
        errors++;
        $display("FAIL async_release: edge %0d out=%0d expected %0d", edges, out, exp);
      end
    end
  endtask

  task automatic test_reset_at_wrap();
    int exp;
    while (edges < 59) begin
      edges++;
      sb.push_back(edges % 60);
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      if (out !== 6'(exp)) begin
        errors++;
        $display("FAIL rwrap_pre: edge %0d out=%0d expected %0d", edges, out, exp);
      end
    end
    #4;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 6'd0) begin
      errors++;
      $display("FAIL rwrap_clear: out=%0d expected 0", out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    for (int i = 0; i < 3; i++) begin
      edges++;
      sb.push_back(edges % 60);
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      if (out !== 6'(exp)) begin
        errors++;
        $display("FAIL rwrap_restart: edge %0d out=%0d expected %0d", edges, out, exp);
      end
    end
  endtask

  task automatic test_param();
    int exp;
    int n;
    @(negedge clk);
    rst_p_n = 1'b1;
    n = 0;
    for (int i = 0; i < 25; i++) begin
      n++;
      sbp.push_back(n % 10);
      @(posedge clk);
      #1;
      exp = sbp.pop_front();
      checks++;
      if (out_p !== 4'(exp)) begin
        errors++;
        $display("FAIL param_seq: edge %0d out_p=%0d expected %0d", n, out_p, exp);
      end
      if (n == 9) begin
        checks++;
        if (out_p !== 4'd9) begin
          errors++;
          $display("FAIL param_9: out_p=%0d expected 9", out_p);
        end
      end
      if (n == 10) begin
        checks++;
        if (out_p !== 4'd0) begin
          errors++;
          $display("FAIL param_wrap: out_p=%0d expected 0", out_p);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_async_reset();
    test_reset_at_wrap();
    test_param();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
